lsu_hs: RTL and testbench

- Parametrised, handshake-based successor of the single-cycle load/store unit.
- Accepts one load/store at a time from the execute stage over a valid/ready channel.
- Issues an aligned, byte-strobed request to a data-memory port with variable latency, then returns the extended load data or store acknowledgement to writeback over a second valid/ready channel.
- Sits between EXU and the data-memory bus. It replaces the direct DPI-C access with a bus-style interface that a DPI-C memory model or an SRAM/AXI bridge can drive.

---
 rtl/lsu_hs_if.sv | 49 ++++
 rtl/lsu_hs.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_hs.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_hs_if.sv
// Handshake channels around lsu_hs: EXU request, data-memory port, writeback result.
// The LSU is the slave on the EXU channel and the master on the memory and writeback channels.
interface lsu_hs_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_wen;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;

  modport master (output in_valid, in_wen, in_funct3, in_addr, in_wdata, input in_ready);
  modport slave  (input in_valid, in_wen, in_funct3, in_addr, in_wdata, output in_ready);
endinterface

interface lsu_hs_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_wen;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_rdata;
  logic                  mem_rsp_err;

  modport master (output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err);
  modport slave  (input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
                  output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err);
endinterface

interface lsu_hs_rsp_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;
  logic              out_misalign;

  modport master (output out_valid, out_rdata, out_err, out_misalign, input out_ready);
  modport slave  (input out_valid, out_rdata, out_err, out_misalign, output out_ready);
endinterface

// File: rtl/lsu_hs.sv
// lsu_hs: one-at-a-time load/store unit between EXU and a variable-latency data-memory port.
// Define LSU_MISALIGN_EN to trap naturally-misaligned accesses instead of issuing them.
module lsu_hs #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_hs_req_if.slave   exu,
  lsu_hs_mem_if.master  mem,
  lsu_hs_rsp_if.master  wbu
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            r_state;
  logic              r_wen;
  logic [2:0]        r_funct3;
  logic [OFF_W-1:0]  r_off;
  logic              r_in_ready;
  logic              r_mem_req_valid;
  logic              r_mem_wen;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic              r_out_valid;
  logic              r_out_err;
  logic [DATA_W-1:0] r_out_rdata;

  logic              w_legal;
  logic [OFF_W-1:0]  w_off;
  logic [7:0]        w_strb_base;
  logic [STRB_W-1:0] w_strb;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [ADDR_W-1:0] w_addr_al;
  logic [DATA_W-1:0] w_rsp_sh;
  logic              w_sgn;
  logic [DATA_W-1:0] w_load_w;
  logic [DATA_W-1:0] w_load;

  // Size legality depends on bus width: doubleword and lwu exist only on a 64-bit bus.
  always_comb begin
    w_legal = 1'b0;
    if (exu.in_wen) begin
      case (exu.in_funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b011:                 w_legal = (DATA_W == 64);
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (exu.in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        3'b011, 3'b110:                         w_legal = (DATA_W == 64);
        default:                                w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (exu.in_funct3[1:0])
      2'd0:    w_strb_base = 8'h01;
      2'd1:    w_strb_base = 8'h03;
      2'd2:    w_strb_base = 8'h0f;
      default: w_strb_base = 8'hff;
    endcase
  end

  assign w_off      = exu.in_addr[OFF_W-1:0];
  assign w_strb     = STRB_W'(w_strb_base << w_off);
  assign w_wdata_sh = exu.in_wdata << {w_off, 3'b000};
  assign w_addr_al  = {exu.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef LSU_MISALIGN_EN
  logic w_misalign;
  logic r_out_misalign;

  always_comb begin
    case (exu.in_funct3[1:0])
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = exu.in_addr[0];
      2'd2:    w_misalign = |exu.in_addr[1:0];
      default: w_misalign = |exu.in_addr[2:0];
    endcase
  end

  assign wbu.out_misalign = r_out_misalign;
`else
  assign wbu.out_misalign = 1'b0;
`endif

  // Load path: bring the addressed lane down to bit 0, then extend to the bus width.
  assign w_rsp_sh = mem.mem_rsp_rdata >> {r_off, 3'b000};
  assign w_sgn    = ~r_funct3[2];

  generate
    if (DATA_W == 64) begin : g_word64
      assign w_load_w = {{32{w_sgn & w_rsp_sh[31]}}, w_rsp_sh[31:0]};
    end else begin : g_word32
      assign w_load_w = w_rsp_sh;
    end
  endgenerate

  always_comb begin
    case (r_funct3[1:0])
      2'd0:    w_load = {{(DATA_W-8){w_sgn & w_rsp_sh[7]}}, w_rsp_sh[7:0]};
      2'd1:    w_load = {{(DATA_W-16){w_sgn & w_rsp_sh[15]}}, w_rsp_sh[15:0]};
      2'd2:    w_load = w_load_w;
      default: w_load = w_rsp_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_wen           <= 1'b0;
      r_funct3        <= 3'b000;
      r_off           <= '0;
      r_in_ready      <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_wen       <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_wstrb     <= '0;
      r_out_valid     <= 1'b0;
      r_out_err       <= 1'b0;
      r_out_rdata     <= '0;
`ifdef LSU_MISALIGN_EN
      r_out_misalign  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (exu.in_valid && r_in_ready) begin
            r_wen      <= exu.in_wen;
            r_funct3   <= exu.in_funct3;
            r_off      <= w_off;
            r_in_ready <= 1'b0;
            if (!w_legal) begin
              r_state     <= RESP;
              r_out_valid <= 1'b1;
              r_out_err   <= 1'b1;
              r_out_rdata <= '0;
`ifdef LSU_MISALIGN_EN
            end else if (w_misalign) begin
              r_state        <= RESP;
              r_out_valid    <= 1'b1;
              r_out_misalign <= 1'b1;
              r_out_rdata    <= '0;
`endif
            end else begin
              r_state         <= REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_wen       <= exu.in_wen;
              r_mem_addr      <= w_addr_al;
              r_mem_wdata     <= exu.in_wen ? w_wdata_sh : '0;
              r_mem_wstrb     <= exu.in_wen ? w_strb : '0;
            end
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_rsp_valid) begin
            r_out_valid <= 1'b1;
            r_out_err   <= mem.mem_rsp_err;
            r_out_rdata <= (mem.mem_rsp_err || r_wen) ? '0 : w_load;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (wbu.out_ready) begin
            r_out_valid    <= 1'b0;
            r_out_err      <= 1'b0;
            r_out_rdata    <= '0;
`ifdef LSU_MISALIGN_EN
            r_out_misalign <= 1'b0;
`endif
            r_in_ready     <= 1'b1;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign exu.in_ready      = r_in_ready;
  assign mem.mem_req_valid = r_mem_req_valid;
  assign mem.mem_wen       = r_mem_wen;
  assign mem.mem_addr      = r_mem_addr;
  assign mem.mem_wdata     = r_mem_wdata;
  assign mem.mem_wstrb     = r_mem_wstrb;
  assign wbu.out_valid     = r_out_valid;
  assign wbu.out_err       = r_out_err;
  assign wbu.out_rdata     = r_out_rdata;
endmodule

// File: tb/tb_lsu_hs.sv
// Directed self-checking bench for lsu_hs at DATA_W=32; a driver task runs one transaction
// against a scripted memory and each test task checks the recorded results inline.
module tb_lsu_hs;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lsu_hs_req_if #(.ADDR_W(32), .DATA_W(32)) exu_if ();
  lsu_hs_mem_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();
  lsu_hs_rsp_if #(.DATA_W(32))              wb_if ();

  lsu_hs #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .exu   (exu_if),
    .mem   (mem_if),
    .wbu   (wb_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        t_req_seen, t_valid, t_unstable, t_busy_bad, t_extra_req, t_ready_after;
  logic        t_wen, t_err, t_mis;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_wstrb;
  int          t_lat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic rerr,
                         input int req_stall, input int rsp_delay, input int out_stall);
    int n;
    logic [31:0] s_rdata;
    logic        s_err, s_mis;
    t_req_seen = 0; t_valid = 0; t_unstable = 0; t_busy_bad = 0; t_extra_req = 0;
    t_ready_after = 0; t_lat = 0;
    t_wen = 0; t_addr = 0; t_wdata = 0; t_wstrb = 0; t_rdata = 0; t_err = 0; t_mis = 0;
    exu_if.in_valid = 1'b1; exu_if.in_wen = wen; exu_if.in_funct3 = f3;
    exu_if.in_addr = addr; exu_if.in_wdata = wdata;
    step();
    exu_if.in_valid = 1'b0;
    n = 0;
    while (!mem_if.mem_req_valid && !wb_if.out_valid && n < 20) begin
      step(); n++; t_lat++;
    end
    if (mem_if.mem_req_valid) begin
      t_req_seen = 1;
      t_wen = mem_if.mem_wen; t_addr = mem_if.mem_addr;
      t_wdata = mem_if.mem_wdata; t_wstrb = mem_if.mem_wstrb;
      repeat (req_stall) begin
        step(); t_lat++;
        if (!mem_if.mem_req_valid || mem_if.mem_wen !== t_wen || mem_if.mem_addr !== t_addr ||
            mem_if.mem_wdata !== t_wdata || mem_if.mem_wstrb !== t_wstrb) t_unstable = 1;
        if (exu_if.in_ready) t_busy_bad = 1;
      end
      mem_if.mem_req_ready = 1'b1;
      step(); t_lat++;
      mem_if.mem_req_ready = 1'b0;
      repeat (rsp_delay) begin
        step(); t_lat++;
        if (mem_if.mem_req_valid) t_extra_req = 1;
        if (wb_if.out_valid) t_unstable = 1;
        if (exu_if.in_ready) t_busy_bad = 1;
      end
      mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_rdata = rdata; mem_if.mem_rsp_err = rerr;
      step(); t_lat++;
      mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_rdata = '0; mem_if.mem_rsp_err = 1'b0;
      n = 0;
      while (!wb_if.out_valid && n < 20) begin
        step(); n++; t_lat++;
      end
    end
    if (wb_if.out_valid) begin
      t_valid = 1;
      t_rdata = wb_if.out_rdata; t_err = wb_if.out_err; t_mis = wb_if.out_misalign;
      s_rdata = t_rdata; s_err = t_err; s_mis = t_mis;
      repeat (out_stall) begin
        step();
        if (!wb_if.out_valid || wb_if.out_rdata !== s_rdata || wb_if.out_err !== s_err ||
            wb_if.out_misalign !== s_mis) t_unstable = 1;
        if (exu_if.in_ready) t_busy_bad = 1;
        if (mem_if.mem_req_valid) t_extra_req = 1;
      end
      wb_if.out_ready = 1'b1;
      step();
      wb_if.out_ready = 1'b0;
      t_ready_after = exu_if.in_ready && !wb_if.out_valid;
    end
    $display("txn wen=%0d f3=%0d addr=%h req=%0d maddr=%h wdata=%h wstrb=%b -> valid=%0d rdata=%h err=%0d mis=%0d lat=%0d",
             wen, f3, addr, t_req_seen, t_addr, t_wdata, t_wstrb, t_valid, t_rdata, t_err, t_mis, t_lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exu_if.in_valid = 1'b1; exu_if.in_wen = 1'b0; exu_if.in_funct3 = 3'b010;
    exu_if.in_addr = 32'h8000_0000; exu_if.in_wdata = 32'h0;
    step(); step();
    n_cmp++; if (exu_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", exu_if.in_ready); end
    n_cmp++; if (mem_if.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", mem_if.mem_req_valid); end
    n_cmp++; if (wb_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", wb_if.out_valid); end
    n_cmp++; if ({mem_if.mem_wen, wb_if.out_err, wb_if.out_misalign} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {mem_if.mem_wen, wb_if.out_err, wb_if.out_misalign}); end
    n_cmp++; if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb, wb_if.out_rdata} !== 100'd0) begin n_bad++; $display("FAIL rst_fields: got %h want 0", {mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb, wb_if.out_rdata}); end
    exu_if.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_cmp++; if (mem_if.mem_req_valid !== 1'b0 || wb_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_capture: got req=%b out=%b want 0 0", mem_if.mem_req_valid, wb_if.out_valid); end
  endtask

  task automatic test_load();
    run_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AB_CDEF, 1'b0, 0, 0, 0);
    n_cmp++; if (t_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL lb_addr: got %h want 80000000", t_addr); end
    n_cmp++; if (t_wstrb !== 4'b0000 || t_wen !== 1'b0) begin n_bad++; $display("FAIL lb_strb: got wstrb=%b wen=%b want 0000 0", t_wstrb, t_wen); end
    n_cmp++; if (t_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", t_rdata); end
    n_cmp++; if (t_lat !== 2) begin n_bad++; $display("FAIL lb_latency: got %0d want 2", t_lat); end
    run_txn(1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80AB_CDEF, 1'b0, 0, 0, 0);
    n_cmp++; if (t_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_rdata: got %h want 00000080", t_rdata); end
    run_txn(1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_1234, 1'b0, 0, 0, 0);
    n_cmp++; if (t_rdata !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_rdata: got %h want ffff8001", t_rdata); end
    run_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_1234, 1'b0, 0, 0, 0);
    n_cmp++; if (t_rdata !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_rdata: got %h want 00008001", t_rdata); end
  endtask

  task automatic test_store();
    run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    n_cmp++; if (t_wdata !== 32'h5678_0000) begin n_bad++; $display("FAIL sh_wdata: got %h want 56780000", t_wdata); end
    n_cmp++; if (t_wstrb !== 4'b1100 || t_wen !== 1'b1) begin n_bad++; $display("FAIL sh_strb: got wstrb=%b wen=%b want 1100 1", t_wstrb, t_wen); end
    n_cmp++; if (t_valid !== 1'b1 || t_rdata !== 32'h0 || t_err !== 1'b0) begin n_bad++; $display("FAIL sh_ack: got valid=%b rdata=%h err=%b want 1 0 0", t_valid, t_rdata, t_err); end
    run_txn(1'b1, 3'b000, 32'h8000_0001, 32'hDEAD_BEAB, 32'h0, 1'b0, 0, 0, 0);
    n_cmp++; if (t_wdata !== 32'hADBE_AB00 || t_wstrb !== 4'b0010) begin n_bad++; $display("FAIL sb_lane: got wdata=%h wstrb=%b want adbeab00 0010", t_wdata, t_wstrb); end
  endtask

  task automatic test_stall();
    run_txn(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 5, 2);
    n_cmp++; if (t_unstable !== 1'b0) begin n_bad++; $display("FAIL stall_stable: got unstable=%b want 0", t_unstable); end
    n_cmp++; if (t_busy_bad !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got early in_ready=%b want 0", t_busy_bad); end
    n_cmp++; if (t_extra_req !== 1'b0) begin n_bad++; $display("FAIL stall_single_txn: got extra req=%b want 0", t_extra_req); end
    n_cmp++; if (t_lat !== 10) begin n_bad++; $display("FAIL stall_latency: got %0d want 10", t_lat); end
    n_cmp++; if (t_addr !== 32'h8000_0004 || t_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL stall_data: got addr=%h rdata=%h want 80000004 deadbeef", t_addr, t_rdata); end
  endtask

  task automatic test_errors();
    run_txn(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h1111_1111, 1'b0, 0, 0, 0);
    n_cmp++; if (t_req_seen !== 1'b0) begin n_bad++; $display("FAIL ld_no_req: got req=%b want 0", t_req_seen); end
    n_cmp++; if (t_valid !== 1'b1 || t_err !== 1'b1 || t_rdata !== 32'h0 || t_mis !== 1'b0) begin n_bad++; $display("FAIL ld_err: got valid=%b err=%b rdata=%h mis=%b want 1 1 0 0", t_valid, t_err, t_rdata, t_mis); end
    run_txn(1'b1, 3'b111, 32'h8000_0000, 32'h5555_5555, 32'h0, 1'b0, 0, 0, 0);
    n_cmp++; if (t_req_seen !== 1'b0 || t_err !== 1'b1) begin n_bad++; $display("FAIL st111_err: got req=%b err=%b want 0 1", t_req_seen, t_err); end
    run_txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hFFFF_FFFF, 1'b1, 0, 1, 0);
    n_cmp++; if (t_req_seen !== 1'b1 || t_err !== 1'b1 || t_rdata !== 32'h0) begin n_bad++; $display("FAIL lw_buserr: got req=%b err=%b rdata=%h want 1 1 0", t_req_seen, t_err, t_rdata); end
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'hAABB_CCDD, 1'b0, 0, 0, 0);
`ifdef LSU_MISALIGN_EN
    n_cmp++; if (t_req_seen !== 1'b0) begin n_bad++; $display("FAIL mis_no_req: got req=%b want 0", t_req_seen); end
    n_cmp++; if (t_mis !== 1'b1 || t_err !== 1'b0 || t_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_flag: got mis=%b err=%b rdata=%h want 1 0 0", t_mis, t_err, t_rdata); end
`else
    n_cmp++; if (t_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL mis_addr: got %h want 80000000", t_addr); end
    n_cmp++; if (t_rdata !== 32'h0000_AABB || t_mis !== 1'b0) begin n_bad++; $display("FAIL mis_rdata: got rdata=%h mis=%b want 0000aabb 0", t_rdata, t_mis); end
`endif
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0102_0304, 1'b0, 0, 0, 0);
    n_cmp++; if (t_ready_after !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", t_ready_after); end
    run_txn(1'b1, 3'b010, 32'h8000_0024, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 0, 0);
    n_cmp++; if (t_wdata !== 32'hCAFE_F00D || t_wstrb !== 4'b1111 || t_addr !== 32'h8000_0024) begin n_bad++; $display("FAIL b2b_sw: got addr=%h wdata=%h wstrb=%b want 80000024 cafef00d 1111", t_addr, t_wdata, t_wstrb); end
  endtask

  task automatic test_reset_wait();
    logic seen;
    exu_if.in_valid = 1'b1; exu_if.in_wen = 1'b0; exu_if.in_funct3 = 3'b010;
    exu_if.in_addr = 32'h8000_0008; exu_if.in_wdata = 32'h0;
    step();
    exu_if.in_valid = 1'b0;
    n_cmp++; if (mem_if.mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rw_req: got %b want 1", mem_if.mem_req_valid); end
    mem_if.mem_req_ready = 1'b1;
    step();
    mem_if.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (exu_if.in_ready !== 1'b1 || mem_if.mem_req_valid !== 1'b0 || wb_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rw_idle: got in_ready=%b req=%b out=%b want 1 0 0", exu_if.in_ready, mem_if.mem_req_valid, wb_if.out_valid); end
    mem_if.mem_rsp_valid = 1'b1; mem_if.mem_rsp_rdata = 32'h1234_5678;
    step();
    mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_rdata = '0;
    seen = 1'b0;
    repeat (4) begin
      if (wb_if.out_valid || !exu_if.in_ready) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rw_late_rsp: got spurious activity=%b want 0", seen); end
  endtask

  initial begin
    rst_n = 1'b0;
    exu_if.in_valid = 1'b0; exu_if.in_wen = 1'b0; exu_if.in_funct3 = 3'b000;
    exu_if.in_addr = '0; exu_if.in_wdata = '0;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0; mem_if.mem_rsp_err = 1'b0;
    wb_if.out_ready = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_stall();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
